// File: rtl/cache_perf_monitor.sv
// Multi-channel cache profiler: per-class event counters and latency accumulators
// gated by a PC window, read back through a registered select port. Macro: PROFILER_MAX_LAT_EN.
module cache_perf_monitor #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NCH      = 2,
    parameter int unsigned     CNT_W    = 32,
    parameter int unsigned     LAT_W    = 40,
    parameter logic [XLEN-1:0] START_PC = XLEN'(32'h80000088),
    parameter logic [XLEN-1:0] STOP_PC  = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  pc_addr_i,
    input  logic             clear_i,
    input  logic [NCH-1:0]   strobe_i,
    input  logic [NCH-1:0]   hit_i,
    input  logic [NCH-1:0]   rw_i,
    input  logic [NCH-1:0]   dirty_i,
    input  logic [NCH-1:0]   flush_i,
    input  logic [NCH-1:0]   ready_i,
    input  logic [2:0]       rd_ch_i,
    input  logic [3:0]       rd_idx_i,
    output logic [LAT_W-1:0] rd_data_o,
    output logic             active_o
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    function automatic logic [2:0] classify(input logic f, input logic h,
                                            input logic w, input logic d);
        if (f)      return 3'd0;
        else if (h) return w ? 3'd1 : 3'd2;
        else if (w) return d ? 3'd4 : 3'd3;
        else        return d ? 3'd6 : 3'd5;
    endfunction

    logic                      start_hit, stop_hit;
    logic [NCH-1:0][LAT_W-1:0] rd_all;
    logic [LAT_W-1:0]          rd_sel;

    assign start_hit = (pc_addr_i == START_PC);
    assign stop_hit  = (STOP_PC != '0) && (pc_addr_i == STOP_PC);

    // Measurement window; stop wins over start, clear leaves it alone
    always_ff @(posedge clk_i) begin
        if (rst_i)          active_o <= 1'b0;
        else if (stop_hit)  active_o <= 1'b0;
        else if (start_hit) active_o <= 1'b1;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_t           state_q, state_d;
        logic [2:0]       cls_c, cls_q, cls_d, commit_cls;
        logic             act_q, act_d, inc_cnt, inc_drop, commit;
        logic [LAT_W-1:0] cur_lat_q, cur_lat_d, lat_inc, commit_lat, rd_val;
        logic [LAT_W:0]   lat_sum;
        logic [CNT_W-1:0] cnt_q [8];   // entry 7 holds the dropped-strobe count
        logic [LAT_W-1:0] lat_q [7];
`ifdef PROFILER_MAX_LAT_EN
        logic [LAT_W-1:0] max_q;
`endif

        assign cls_c   = classify(flush_i[c], hit_i[c], rw_i[c], dirty_i[c]);
        assign lat_inc = (&cur_lat_q) ? cur_lat_q : cur_lat_q + LAT_W'(1);
        assign lat_sum = (LAT_W+1)'(lat_q[commit_cls]) + (LAT_W+1)'(commit_lat);

        always_ff @(posedge clk_i) begin
            if (rst_i || clear_i) begin
                state_q   <= S_IDLE;
                cls_q     <= 3'd0;
                act_q     <= 1'b0;
                cur_lat_q <= '0;
            end else begin
                state_q   <= state_d;
                cls_q     <= cls_d;
                act_q     <= act_d;
                cur_lat_q <= cur_lat_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            cls_d      = cls_q;
            act_d      = act_q;
            cur_lat_d  = cur_lat_q;
            inc_cnt    = 1'b0;
            inc_drop   = 1'b0;
            commit     = 1'b0;
            commit_cls = cls_q;
            commit_lat = '0;
            case (state_q)
                S_IDLE: begin
                    if (strobe_i[c]) begin
                        cls_d   = cls_c;
                        act_d   = active_o;
                        inc_cnt = active_o;
                        if (ready_i[c]) begin
                            commit     = active_o;
                            commit_cls = cls_c;
                            commit_lat = LAT_W'(1);
                        end else begin
                            cur_lat_d = LAT_W'(1);
                            state_d   = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    inc_drop = strobe_i[c] & active_o;
                    if (ready_i[c]) begin
                        commit     = act_q;
                        commit_lat = lat_inc;
                        cur_lat_d  = '0;
                        state_d    = S_IDLE;
                    end else begin
                        cur_lat_d = lat_inc;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Saturating counters and accumulators; clear beats any same-cycle update
        always_ff @(posedge clk_i) begin
            if (rst_i || clear_i) begin
                for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
                for (int i = 0; i < 7; i++) lat_q[i] <= '0;
`ifdef PROFILER_MAX_LAT_EN
                max_q <= '0;
`endif
            end else begin
                if (inc_cnt && !(&cnt_q[cls_c]))
                    cnt_q[cls_c] <= cnt_q[cls_c] + CNT_W'(1);
                if (inc_drop && !(&cnt_q[7]))
                    cnt_q[7] <= cnt_q[7] + CNT_W'(1);
                if (commit)
                    lat_q[commit_cls] <= lat_sum[LAT_W] ? '1 : lat_sum[LAT_W-1:0];
`ifdef PROFILER_MAX_LAT_EN
                if (commit && (commit_lat > max_q))
                    max_q <= commit_lat;
`endif
            end
        end

        always_comb begin
            rd_val = '0;
            if (!rd_idx_i[3])
                rd_val = LAT_W'(cnt_q[rd_idx_i[2:0]]);
            else if (rd_idx_i[2:0] != 3'd7)
                rd_val = lat_q[rd_idx_i[2:0]];
`ifdef PROFILER_MAX_LAT_EN
            else
                rd_val = max_q;
`endif
        end

        assign rd_all[c] = rd_val;
    end

    // Channels beyond NCH read as zero
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NCH; i++)
            if (rd_ch_i == 3'(i)) rd_sel = rd_all[i];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rd_data_o <= '0;
        else       rd_data_o <= rd_sel;
    end

endmodule

// File: tb/tb_cache_perf_monitor.sv
// Bench for cache_perf_monitor: a default instance and a CNT_W=4 / STOP_PC instance
// share stimulus and are checked against a cycle-level reference model.
module tb_cache_perf_monitor;
    localparam int NCH   = 2;
    localparam int LAT_W = 40;
    localparam logic [31:0] START = 32'h80000088;
    localparam logic [31:0] STOP  = 32'h80000100;
    localparam logic [31:0] IDLE_PC = 32'h00001000;

    logic             clk = 1'b0;
    logic             rst, clear;
    logic [31:0]      pc;
    logic [NCH-1:0]   strobe, hit, rw, dirty, flush, ready;
    logic [2:0]       rd_ch;
    logic [3:0]       rd_idx;
    logic [LAT_W-1:0] rd_a, rd_b;
    logic             act_a, act_b;

    always #5 clk = ~clk;

    cache_perf_monitor u_a (
        .clk_i(clk), .rst_i(rst), .pc_addr_i(pc), .clear_i(clear),
        .strobe_i(strobe), .hit_i(hit), .rw_i(rw), .dirty_i(dirty), .flush_i(flush),
        .ready_i(ready), .rd_ch_i(rd_ch), .rd_idx_i(rd_idx),
        .rd_data_o(rd_a), .active_o(act_a)
    );

    cache_perf_monitor #(.CNT_W(4), .STOP_PC(STOP)) u_b (
        .clk_i(clk), .rst_i(rst), .pc_addr_i(pc), .clear_i(clear),
        .strobe_i(strobe), .hit_i(hit), .rw_i(rw), .dirty_i(dirty), .flush_i(flush),
        .ready_i(ready), .rd_ch_i(rd_ch), .rd_idx_i(rd_idx),
        .rd_data_o(rd_b), .active_o(act_b)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model, index [cfg][channel][...]; cfg 0 = u_a, cfg 1 = u_b
    longint unsigned m_cnt [2][NCH][8];
    longint unsigned m_lat [2][NCH][7];
    longint unsigned m_max [2][NCH];
    bit              m_act [2];
    bit              m_pend [2][NCH];
    bit              m_pact [2][NCH];
    int              m_start[2][NCH];
    int              m_cls  [2][NCH];

    function automatic longint unsigned cnt_lim(int k);
        return (k == 0) ? 64'hFFFF_FFFF : 64'hF;
    endfunction

    function automatic int classify(bit f, bit h, bit w, bit d);
        if (f) return 0;
        if (h) return w ? 1 : 2;
        if (w) return d ? 4 : 3;
        return d ? 6 : 5;
    endfunction

    function automatic longint unsigned sat_add(longint unsigned a, longint unsigned b,
                                                longint unsigned lim);
        return (a + b > lim) ? lim : a + b;
    endfunction

    function automatic logic [LAT_W-1:0] expected(int k, int ch, int idx);
        if (ch >= NCH) return '0;
        if (idx <= 7)  return LAT_W'(m_cnt[k][ch][idx]);
        if (idx <= 14) return LAT_W'(m_lat[k][ch][idx-8]);
`ifdef PROFILER_MAX_LAT_EN
        return LAT_W'(m_max[k][ch]);
`else
        return '0;
`endif
    endfunction

    task automatic model_commit(int k, int ch, int cls, longint unsigned lat);
        m_lat[k][ch][cls] = sat_add(m_lat[k][ch][cls], lat, 64'hFF_FFFF_FFFF);
        if (lat > m_max[k][ch]) m_max[k][ch] = lat;
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                int c;
                c = classify(flush[ch], hit[ch], rw[ch], dirty[ch]);
                if (rst || clear) begin
                    for (int i = 0; i < 8; i++) m_cnt[k][ch][i] = 0;
                    for (int i = 0; i < 7; i++) m_lat[k][ch][i] = 0;
                    m_max[k][ch]  = 0;
                    m_pend[k][ch] = 0;
                end else if (!m_pend[k][ch]) begin
                    if (strobe[ch]) begin
                        if (m_act[k]) m_cnt[k][ch][c] = sat_add(m_cnt[k][ch][c], 1, cnt_lim(k));
                        if (ready[ch]) begin
                            if (m_act[k]) model_commit(k, ch, c, 1);
                        end else begin
                            m_pend[k][ch]  = 1;
                            m_start[k][ch] = cyc;
                            m_cls[k][ch]   = c;
                            m_pact[k][ch]  = m_act[k];
                        end
                    end
                end else begin
                    if (strobe[ch] && m_act[k])
                        m_cnt[k][ch][7] = sat_add(m_cnt[k][ch][7], 1, cnt_lim(k));
                    if (ready[ch]) begin
                        if (m_pact[k][ch])
                            model_commit(k, ch, m_cls[k][ch], longint'(cyc - m_start[k][ch] + 1));
                        m_pend[k][ch] = 0;
                    end
                end
            end
            if (rst) m_act[k] = 0;
            else if (k == 1 && pc == STOP) m_act[k] = 0;
            else if (pc == START) m_act[k] = 1;
        end
    endtask

    // One clock: advance the model with the current inputs, then check the window flag
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        vectors += 2;
        if (act_a !== m_act[0]) begin
            errors++;
            $display("FAIL active_a cyc%0d: got %b expected %b", cyc, act_a, m_act[0]);
        end
        if (act_b !== m_act[1]) begin
            errors++;
            $display("FAIL active_b cyc%0d: got %b expected %b", cyc, act_b, m_act[1]);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; clear = 0; pc = IDLE_PC;
        strobe = '0; hit = '0; rw = '0; dirty = '0; flush = '0; ready = '0;
    endtask

    task automatic set_class(int ch, bit f, bit h, bit w, bit d);
        flush[ch] = f; hit[ch] = h; rw[ch] = w; dirty[ch] = d;
    endtask

    task automatic read_check(int ch, int idx);
        logic [LAT_W-1:0] ea, eb;
        rd_ch  = 3'(ch);
        rd_idx = 4'(idx);
        ea = expected(0, ch, idx);
        eb = expected(1, ch, idx);
        step();
        vectors += 2;
        if (rd_a !== ea) begin
            errors++;
            $display("FAIL read_a ch%0d idx%0d: got %0d expected %0d", ch, idx, rd_a, ea);
        end
        if (rd_b !== eb) begin
            errors++;
            $display("FAIL read_b ch%0d idx%0d: got %0d expected %0d", ch, idx, rd_b, eb);
        end
    endtask

    task automatic read_all();
        idle_inputs();
        for (int ch = 0; ch < 8; ch++)
            for (int idx = 0; idx < 16; idx++)
                read_check(ch, idx);
    endtask

    task automatic test_reset();
        idle_inputs();
        rd_ch = 3'd0; rd_idx = 4'd0;
        rst = 1;
        step();
        step();
        rst = 0;
        vectors += 2;
        if (rd_a !== '0) begin errors++; $display("FAIL reset_rd_a: got %0d expected 0", rd_a); end
        if (rd_b !== '0) begin errors++; $display("FAIL reset_rd_b: got %0d expected 0", rd_b); end
        read_all();
    endtask

    task automatic test_window();
        idle_inputs();
        strobe[0] = 1; ready[0] = 1; set_class(0, 0, 1, 0, 0);
        pc = 32'h0;
        step();
        idle_inputs();
        pc = START;
        step();
        pc = IDLE_PC;
        vectors++;
        if (act_a !== 1'b1) begin errors++; $display("FAIL window_open: got %b expected 1", act_a); end
        read_check(0, 2);
        read_check(0, 9);
    endtask

    task automatic test_read_hit();
        for (int n = 0; n < 3; n++) begin
            idle_inputs();
            strobe[1] = 1; ready[1] = 1; set_class(1, 0, 1, 0, 0);
            step();
        end
        read_all();
    endtask

    task automatic test_wmd();
        idle_inputs();
        strobe[0] = 1; set_class(0, 0, 0, 1, 1);
        step();
        idle_inputs();
        for (int n = 0; n < 4; n++) step();
        ready[0] = 1;
        step();
        idle_inputs();
        read_check(0, 4);
        read_check(0, 11);
        read_check(0, 15);
    endtask

    task automatic test_drop_clear();
        idle_inputs();
        strobe[1] = 1; set_class(1, 0, 0, 0, 0);
        step();
        strobe[1] = 1; set_class(1, 0, 1, 1, 0);
        step();
        idle_inputs();
        read_check(1, 7);
        read_check(1, 1);
        read_check(1, 5);
        clear = 1;
        step();
        clear = 0;
        ready[1] = 1;
        step();
        read_all();
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 20; n++) begin
            idle_inputs();
            strobe[0] = 1; ready[0] = 1; set_class(0, 0, 0, 0, 0);
            step();
        end
        idle_inputs();
        read_check(0, 5);
        read_check(0, 13);
    endtask

    task automatic test_stop();
        idle_inputs();
        strobe[0] = 1; set_class(0, 0, 1, 1, 0);
        step();
        idle_inputs();
        pc = STOP;
        step();
        pc = IDLE_PC;
        vectors += 2;
        if (act_b !== 1'b0) begin errors++; $display("FAIL stop_b: got %b expected 0", act_b); end
        if (act_a !== 1'b1) begin errors++; $display("FAIL stop_a: got %b expected 1", act_a); end
        step();
        ready[0] = 1;
        step();
        idle_inputs();
        strobe[0] = 1; ready[0] = 1; set_class(0, 1, 0, 0, 0);
        step();
        read_all();
    endtask

    // Random traffic with a live readout checked every cycle, then a full dump
    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            logic [LAT_W-1:0] ea, eb;
            int r;
            idle_inputs();
            for (int ch = 0; ch < NCH; ch++) begin
                strobe[ch] = ($urandom_range(0, 9) < 4);
                ready[ch]  = ($urandom_range(0, 9) < 3);
                set_class(ch, ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
            end
            r = int'($urandom_range(0, 99));
            if (r < 3)      pc = START;
            else if (r < 5) pc = STOP;
            else            pc = $urandom;
            clear  = ($urandom_range(0, 199) == 0);
            rd_ch  = 3'($urandom);
            rd_idx = 4'($urandom);
            ea = expected(0, int'(rd_ch), int'(rd_idx));
            eb = expected(1, int'(rd_ch), int'(rd_idx));
            step();
            vectors += 2;
            if (rd_a !== ea) begin
                errors++;
                $display("FAIL rand_a cyc%0d ch%0d idx%0d: got %0d expected %0d", cyc, rd_ch, rd_idx, rd_a, ea);
            end
            if (rd_b !== eb) begin
                errors++;
                $display("FAIL rand_b cyc%0d ch%0d idx%0d: got %0d expected %0d", cyc, rd_ch, rd_idx, rd_b, eb);
            end
        end
        read_all();
    endtask

    initial begin
        test_reset();
        test_window();
        test_read_hit();
        test_wmd();
        test_drop_clear();
        test_saturate();
        test_stop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
